// File: rtl/time_set_ctrl_pkg.sv
// Shared types and constants for the time/alarm set front end.
//   state_t  : edit FSM states
//   hhmm_t   : packed HH:MM BCD payload as carried on the set bus
//   DIG_*    : digit-select encodings driven on edit_digit
//   *_MAX    : per-digit wrap limits
package time_set_ctrl_pkg;

   localparam int unsigned H1_W    = 2;
   localparam int unsigned DIGIT_W = 4;
   localparam int unsigned SEL_W   = 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ED_H1  = 3'd1,
      ST_ED_H0  = 3'd2,
      ST_ED_M1  = 3'd3,
      ST_ED_M0  = 3'd4,
      ST_COMMIT = 3'd5
   } state_t;

   typedef struct packed {
      logic [H1_W-1:0]    h1;
      logic [DIGIT_W-1:0] h0;
      logic [DIGIT_W-1:0] m1;
      logic [DIGIT_W-1:0] m0;
   } hhmm_t;

   localparam logic [SEL_W-1:0] DIG_H1 = 2'd0;
   localparam logic [SEL_W-1:0] DIG_H0 = 2'd1;
   localparam logic [SEL_W-1:0] DIG_M1 = 2'd2;
   localparam logic [SEL_W-1:0] DIG_M0 = 2'd3;

   localparam logic [H1_W-1:0]    H1_MAX       = 2'd2;
   localparam logic [DIGIT_W-1:0] H0_MAX       = 4'd9;
   localparam logic [DIGIT_W-1:0] H0_MAX_AT_20 = 4'd3;
   localparam logic [DIGIT_W-1:0] M1_MAX       = 4'd5;
   localparam logic [DIGIT_W-1:0] M0_MAX       = 4'd9;

   // Increment a BCD digit, wrapping to 0 once it has reached max.
   function automatic logic [DIGIT_W-1:0] wrap_inc(input logic [DIGIT_W-1:0] v,
                                                   input logic [DIGIT_W-1:0] max);
      return (v >= max) ? '0 : DIGIT_W'(v + DIGIT_W'(1));
   endfunction

endpackage

// File: rtl/time_set_ctrl_btn_debounce.sv
// Button conditioner: 2-FF synchronizer, stability counter, rising-edge pulse.
//   clk, rst (async active-low)
//   raw   : asynchronous button input
//   level : accepted (debounced) level
//   press : one-cycle pulse on each accepted 0->1 change
module btn_debounce #(
   parameter int unsigned DB_CYCLES = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int unsigned CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;

   logic [1:0]       r_sync;
   logic [CNT_W-1:0] r_cnt;
   logic             r_level;
   logic             r_level_d;
   logic             r_press;

   // Count consecutive samples that disagree with the accepted level; any
   // agreeing sample restarts the run.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync    <= '0;
         r_cnt     <= '0;
         r_level   <= 1'b0;
         r_level_d <= 1'b0;
         r_press   <= 1'b0;
      end else begin
         r_sync <= {r_sync[0], raw};
         if (r_sync[1] == r_level) begin
            r_cnt <= '0;
         end else if (r_cnt == CNT_W'(DB_CYCLES - 1)) begin
            r_level <= r_sync[1];
            r_cnt   <= '0;
         end else begin
            r_cnt <= CNT_W'(r_cnt + CNT_W'(1));
         end
         r_level_d <= r_level;
         r_press   <= r_level & ~r_level_d;
      end
   end

   assign level = r_level;
   assign press = r_press;

endmodule

// File: rtl/time_set_ctrl.sv
// Button-driven editor for clock and alarm time; writer side of the set port.
//   clk, rst (async active-low)
//   btn_set/btn_alm/btn_inc/btn_next : raw push-buttons
//   cur_h1/h0/m1/m0  : current clock digits, seed for a clock edit
//   h1in/h0in/m1in/m0in : set bus (always the edit registers)
//   clset/alset      : one-cycle commit strobes
//   edit_active/edit_digit/edit_alarm : edit status
module time_set_ctrl
   import time_set_ctrl_pkg::*;
#(
   parameter int unsigned DB_CYCLES = 16,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               btn_set,
   input  logic               btn_alm,
   input  logic               btn_inc,
   input  logic               btn_next,
   input  logic [H1_W-1:0]    cur_h1,
   input  logic [DIGIT_W-1:0] cur_h0,
   input  logic [DIGIT_W-1:0] cur_m1,
   input  logic [DIGIT_W-1:0] cur_m0,
   output logic [H1_W-1:0]    h1in,
   output logic [DIGIT_W-1:0] h0in,
   output logic [DIGIT_W-1:0] m1in,
   output logic [DIGIT_W-1:0] m0in,
   output logic               clset,
   output logic               alset,
   output logic               edit_active,
   output logic [SEL_W-1:0]   edit_digit,
   output logic               edit_alarm
);

   localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   logic w_set_ev, w_alm_ev, w_inc_ev, w_next_ev, w_any_ev;
   logic w_set_lvl, w_alm_lvl, w_inc_lvl, w_next_lvl;
   logic w_unused_lvl;

   state_t           r_state, w_state_n;
   hhmm_t            r_edit, w_edit_n;
   hhmm_t            r_shadow, w_shadow_n;
   hhmm_t            w_cur;
   logic             r_alarm, w_alarm_n;
   logic [TMO_W-1:0] r_tmo, w_tmo_n;
   logic             r_clset, w_clset_n;
   logic             r_alset, w_alset_n;
   logic             r_active, w_active_n;
   logic [SEL_W-1:0] r_digit, w_digit_n;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_set (
      .clk(clk), .rst(rst), .raw(btn_set), .level(w_set_lvl), .press(w_set_ev));
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_alm (
      .clk(clk), .rst(rst), .raw(btn_alm), .level(w_alm_lvl), .press(w_alm_ev));
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_inc (
      .clk(clk), .rst(rst), .raw(btn_inc), .level(w_inc_lvl), .press(w_inc_ev));
   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_next (
      .clk(clk), .rst(rst), .raw(btn_next), .level(w_next_lvl), .press(w_next_ev));

   // Held levels are not needed here; only press events drive the editor.
   assign w_unused_lvl = ^{w_set_lvl, w_alm_lvl, w_inc_lvl, w_next_lvl};

   assign w_any_ev = w_set_ev | w_alm_ev | w_inc_ev | w_next_ev;
   assign w_cur    = '{h1: cur_h1, h0: cur_h0, m1: cur_m1, m0: cur_m0};

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_IDLE;
         r_edit   <= '0;
         r_shadow <= '0;
         r_alarm  <= 1'b0;
         r_tmo    <= '0;
         r_clset  <= 1'b0;
         r_alset  <= 1'b0;
         r_active <= 1'b0;
         r_digit  <= DIG_H1;
      end else begin
         r_state  <= w_state_n;
         r_edit   <= w_edit_n;
         r_shadow <= w_shadow_n;
         r_alarm  <= w_alarm_n;
         r_tmo    <= w_tmo_n;
         r_clset  <= w_clset_n;
         r_alset  <= w_alset_n;
         r_active <= w_active_n;
         r_digit  <= w_digit_n;
      end
   end

   // Next-state, digit edits, and registered-output precompute.
   always_comb begin
      w_state_n  = r_state;
      w_edit_n   = r_edit;
      w_shadow_n = r_shadow;
      w_alarm_n  = r_alarm;
      w_tmo_n    = '0;
      w_clset_n  = 1'b0;
      w_alset_n  = 1'b0;
      w_active_n = 1'b0;
      w_digit_n  = DIG_H1;

      unique case (r_state)
         ST_IDLE: begin
            if (w_set_ev) begin
               w_edit_n  = w_cur;
               w_alarm_n = 1'b0;
               w_state_n = ST_ED_H1;
            end else if (w_alm_ev) begin
               w_edit_n  = r_shadow;
               w_alarm_n = 1'b1;
               w_state_n = ST_ED_H1;
            end
         end
         ST_ED_H1, ST_ED_H0, ST_ED_M1, ST_ED_M0: begin
            w_tmo_n = w_any_ev ? '0 : TMO_W'(r_tmo + TMO_W'(1));
            if (!w_any_ev && (r_tmo == TMO_W'(TIMEOUT - 1))) begin
               w_state_n = ST_IDLE;
            end else if (w_next_ev) begin
               unique case (r_state)
                  ST_ED_H1: w_state_n = ST_ED_H0;
                  ST_ED_H0: w_state_n = ST_ED_M1;
                  ST_ED_M1: w_state_n = ST_ED_M0;
                  default:  w_state_n = ST_COMMIT;
               endcase
            end else if (w_inc_ev) begin
               unique case (r_state)
                  ST_ED_H1: begin
                     w_edit_n.h1 = (r_edit.h1 >= H1_MAX) ? '0 : H1_W'(r_edit.h1 + H1_W'(1));
                     // Entering the 20s would make an illegal hour above 23.
                     if ((w_edit_n.h1 == H1_MAX) && (r_edit.h0 > H0_MAX_AT_20))
                        w_edit_n.h0 = '0;
                  end
                  ST_ED_H0: w_edit_n.h0 = wrap_inc(r_edit.h0,
                                           (r_edit.h1 == H1_MAX) ? H0_MAX_AT_20 : H0_MAX);
                  ST_ED_M1: w_edit_n.m1 = wrap_inc(r_edit.m1, M1_MAX);
                  default:  w_edit_n.m0 = wrap_inc(r_edit.m0, M0_MAX);
               endcase
            end
         end
         ST_COMMIT: begin
            if (r_alarm) w_shadow_n = r_edit;
            w_state_n = ST_IDLE;
         end
         default: w_state_n = ST_IDLE;
      endcase

      // Status/strobe outputs are registered, so decode the upcoming state.
      unique case (w_state_n)
         ST_ED_H1: begin w_active_n = 1'b1; w_digit_n = DIG_H1; end
         ST_ED_H0: begin w_active_n = 1'b1; w_digit_n = DIG_H0; end
         ST_ED_M1: begin w_active_n = 1'b1; w_digit_n = DIG_M1; end
         ST_ED_M0: begin w_active_n = 1'b1; w_digit_n = DIG_M0; end
         ST_COMMIT: begin
            w_clset_n = ~w_alarm_n;
            w_alset_n = w_alarm_n;
         end
         default: ;
      endcase
   end

   assign h1in        = r_edit.h1;
   assign h0in        = r_edit.h0;
   assign m1in        = r_edit.m1;
   assign m0in        = r_edit.m0;
   assign clset       = r_clset;
   assign alset       = r_alset;
   assign edit_active = r_active;
   assign edit_digit  = r_digit;
   assign edit_alarm  = r_alarm;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Directed bench for time_set_ctrl: commit strobes are scoreboarded, edit
// state is checked directly after each button action.
module tb_time_set_ctrl;

   localparam int unsigned DB  = 16;
   localparam int unsigned TMO = 64;

   localparam logic [3:0] B_SET = 4'b1000;
   localparam logic [3:0] B_ALM = 4'b0100;
   localparam logic [3:0] B_INC = 4'b0010;
   localparam logic [3:0] B_NXT = 4'b0001;

   typedef struct packed {
      logic        is_alarm;
      logic [13:0] bus;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_set, btn_alm, btn_inc, btn_next;
   logic [1:0] cur_h1;
   logic [3:0] cur_h0, cur_m1, cur_m0;
   logic [1:0] h1in;
   logic [3:0] h0in, m1in, m0in;
   logic       clset, alset, edit_active, edit_alarm;
   logic [1:0] edit_digit;

   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   logic [13:0] w_bus;
   assign w_bus = {h1in, h0in, m1in, m0in};

   time_set_ctrl #(.DB_CYCLES(DB), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .btn_set(btn_set), .btn_alm(btn_alm), .btn_inc(btn_inc), .btn_next(btn_next),
      .cur_h1(cur_h1), .cur_h0(cur_h0), .cur_m1(cur_m1), .cur_m0(cur_m0),
      .h1in(h1in), .h0in(h0in), .m1in(m1in), .m0in(m0in),
      .clset(clset), .alset(alset),
      .edit_active(edit_active), .edit_digit(edit_digit), .edit_alarm(edit_alarm));

   always #5 clk = ~clk;

   // Monitor: every strobe must match the oldest expected commit.
   always @(negedge clk) begin
      exp_t e;
      if (clset || alset) begin
         n_tests++;
         if (clset && alset) begin
            n_fail++;
            $display("FAIL strobe_excl: clset=%0b alset=%0b both high", clset, alset);
         end else if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_strobe: clset=%0b alset=%0b bus=%h, none expected",
                     clset, alset, w_bus);
         end else begin
            e = sb_q.pop_front();
            if (e.is_alarm !== alset || e.bus !== w_bus) begin
               n_fail++;
               $display("FAIL commit: got alset=%0b bus=%h, expected alset=%0b bus=%h",
                        alset, w_bus, e.is_alarm, e.bus);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold the masked buttons for hi cycles, then release for lo cycles.
   task automatic press(input logic [3:0] m, input int hi, input int lo);
      {btn_set, btn_alm, btn_inc, btn_next} = m;
      cyc(hi);
      {btn_set, btn_alm, btn_inc, btn_next} = 4'b0000;
      cyc(lo);
   endtask

   task automatic tap(input logic [3:0] m);
      press(m, 20, 20);
   endtask

   task automatic set_cur(input logic [13:0] t);
      {cur_h1, cur_h0, cur_m1, cur_m0} = t;
   endtask

   initial begin
      logic [3:0] exp_h0 [4];
      exp_h0 = '{4'd1, 4'd2, 4'd3, 4'd0};

      rst = 1'b0;
      {btn_set, btn_alm, btn_inc, btn_next} = 4'b0000;
      set_cur(14'h0000);
      cyc(3);
      chk("rst_bus",    32'(w_bus), 32'h0);
      chk("rst_active", 32'(edit_active), 32'h0);
      chk("rst_digit",  32'(edit_digit), 32'h0);
      chk("rst_alarm",  32'(edit_alarm), 32'h0);
      chk("rst_strobe", 32'({clset, alset}), 32'h0);
      rst = 1'b1;
      cyc(2);

      // Clock edit 13:47 -> 23:47
      set_cur(14'h1347);
      tap(B_SET);
      chk("ce_active", 32'(edit_active), 32'h1);
      chk("ce_alarm",  32'(edit_alarm), 32'h0);
      chk("ce_digit0", 32'(edit_digit), 32'h0);
      chk("ce_load",   32'(w_bus), 32'h1347);
      tap(B_INC);
      chk("ce_inc_h1", 32'(w_bus), 32'h2347);
      tap(B_NXT);
      chk("ce_digit1", 32'(edit_digit), 32'h1);
      tap(B_NXT);
      tap(B_NXT);
      chk("ce_digit3", 32'(edit_digit), 32'h3);
      sb_q.push_back('{is_alarm: 1'b0, bus: 14'h2347});
      tap(B_NXT);
      chk("ce_idle",   32'(edit_active), 32'h0);
      chk("ce_hold",   32'(w_bus), 32'h2347);

      // H0 clamp from 19:00, then timeout without strobe
      set_cur(14'h1900);
      tap(B_SET);
      tap(B_INC);
      chk("clamp_h1", 32'(w_bus), 32'h2000);
      tap(B_NXT);
      chk("clamp_digit", 32'(edit_digit), 32'h1);
      for (int i = 0; i < 4; i++) begin
         tap(B_INC);
         chk($sformatf("clamp_h0_%0d", i), 32'(h0in), 32'(exp_h0[i]));
      end
      chk("tmo_still_active", 32'(edit_active), 32'h1);
      cyc(100);
      chk("tmo_idle", 32'(edit_active), 32'h0);

      // Alarm edit 00:00 -> 06:30
      tap(B_ALM);
      chk("al_alarm",  32'(edit_alarm), 32'h1);
      chk("al_load",   32'(w_bus), 32'h0000);
      tap(B_NXT);
      for (int i = 0; i < 6; i++) tap(B_INC);
      chk("al_h0", 32'(w_bus), 32'h0600);
      tap(B_NXT);
      for (int i = 0; i < 3; i++) tap(B_INC);
      tap(B_NXT);
      chk("al_bus",   32'(w_bus), 32'h0630);
      chk("al_digit", 32'(edit_digit), 32'h3);
      sb_q.push_back('{is_alarm: 1'b1, bus: 14'h0630});
      tap(B_NXT);
      chk("al_idle", 32'(edit_active), 32'h0);
      set_cur(14'h1111);
      tap(B_ALM);
      chk("al_reload", 32'(w_bus), 32'h0630);
      chk("al_alarm2", 32'(edit_alarm), 32'h1);
      cyc(100);

      // Debounce: 10-cycle glitch ignored, 30-cycle press counts once
      set_cur(14'h1000);
      btn_set = 1'b1;
      cyc(20);
      btn_set = 1'b0;
      btn_inc = 1'b1;
      cyc(10);
      btn_inc = 1'b0;
      cyc(12);
      chk("db_glitch", 32'(w_bus), 32'h1000);
      press(B_INC, 30, 20);
      chk("db_once", 32'(w_bus), 32'h2000);
      cyc(100);
      chk("db_tmo", 32'(edit_active), 32'h0);

      // Priorities
      set_cur(14'h0825);
      tap(B_SET | B_ALM);
      chk("pri_set_wins", 32'(edit_alarm), 32'h0);
      chk("pri_load",     32'(w_bus), 32'h0825);
      tap(B_NXT);
      tap(B_NXT);
      chk("pri_m1", 32'(edit_digit), 32'h2);
      tap(B_INC | B_NXT);
      chk("pri_next_wins", 32'(edit_digit), 32'h3);
      chk("pri_m1_kept",   32'(w_bus), 32'h0825);
      @(posedge clk);
      #3 rst = 1'b0;
      #1;
      chk("mid_rst_bus",    32'(w_bus), 32'h0);
      chk("mid_rst_active", 32'(edit_active), 32'h0);
      chk("mid_rst_digit",  32'(edit_digit), 32'h0);
      chk("mid_rst_strobe", 32'({clset, alset}), 32'h0);
      cyc(3);
      rst = 1'b1;
      cyc(50);

      chk("sb_drained", 32'(sb_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/time_set_ctrl.md
# time_set_ctrl

User-input front end for the alarm clock. It turns four raw push-buttons into BCD digit edits and drives the clock's set interface: the digit bus plus one-cycle `clset` / `alset` commit strobes. It is the writer side of the set port that the clock core samples. It sits between the board buttons and the clock core, and reads back the clock's current hour and minute digits to seed each edit.

## Interface
- `DB_CYCLES`, default 16: consecutive stable samples required to accept a button level.
- `TIMEOUT`, default 1024: idle cycles inside an edit before it aborts.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `btn_set` in 1: raw button; start a clock-time edit.
- `btn_alm` in 1: raw button; start an alarm-time edit.
- `btn_inc` in 1: raw button; increment the selected digit.
- `btn_next` in 1: raw button; advance to the next digit, or commit after the last one.
- `cur_h1` in 2: clock core's hour-tens digit.
- `cur_h0`, `cur_m1`, `cur_m0` in 4 each: clock core's hour-units, minute-tens and minute-units digits.
- `h1in` out 2: set bus, hour tens.
- `h0in`, `m1in`, `m0in` out 4 each: set bus, hour units, minute tens, minute units.
- `clset` out 1: one-cycle strobe that commits the set bus as the clock time.
- `alset` out 1: one-cycle strobe that commits the set bus as the alarm time.
- `edit_active` out 1: high in any edit state.
- `edit_digit` out 2: selected digit; 0=H1, 1=H0, 2=M1, 3=M0.
- `edit_alarm` out 1: edit target; 1 = alarm, 0 = clock.

## Operation
- **Button conditioning.** Each button passes through a 2-FF synchronizer and then a stability counter.
  - The accepted level changes only after `DB_CYCLES` identical consecutive samples.
  - An accepted 0→1 change produces a one-cycle press event. Release produces nothing. A held button produces no repeat.
- **FSM states:** IDLE, ED_H1, ED_H0, ED_M1, ED_M0, COMMIT.
- **IDLE**
  - `set` event: load the edit registers from `cur_*`, set `edit_alarm`=0, go to ED_H1.
  - `alm` event: load the edit registers from the internal alarm shadow, set `edit_alarm`=1, go to ED_H1.
  - Both events in the same cycle: `set` wins.
  - `inc` and `next` events are ignored.
- **ED_x, increment** (on an `inc` event, with wrap):
  - H1 steps 0→1→2→0. If H1 becomes 2 while H0>3, H0 is forced to 0 in the same cycle.
  - H0 steps 0..9 when H1<2, and 0..3 when H1=2.
  - M1 steps 0..5.
  - M0 steps 0..9.
- **ED_x, next:** a `next` event advances ED_H1→ED_H0→ED_M1→ED_M0→COMMIT.
- **Simultaneous events:** `next` and `inc` in the same cycle means `next` wins and `inc` is dropped. `set`/`alm` events are ignored while editing.
- **Timeout:** an idle counter clears on any press event. When it reaches `TIMEOUT`, go to IDLE with no strobe; edits are discarded.
- **COMMIT** lasts exactly one cycle:
  - Asserts `clset` if `edit_alarm`=0, otherwise `alset`.
  - On an alarm commit, the alarm shadow is updated.
  - The next state is IDLE.
- **Set bus:** the bus is the edit registers at all times. It is stable during the strobe cycle and holds its value afterwards.
- **Shadow:** the alarm shadow holds the last committed alarm time.

## Timing
- **Reset values:**
  - Set bus, strobes, `edit_active`, `edit_digit` and `edit_alarm` are all 0.
  - The alarm shadow is 00:00.
  - The FSM is in IDLE. The debouncers reset to accepted level 0 with their counters at 0.
- **Press latency:** a press event is asserted 2+`DB_CYCLES` cycles after the first rising edge that samples the raw button high. The FSM and the edit registers update on the following edge.
- **Commit latency:** the strobe is asserted the cycle after the last `next` event is accepted, and is high for exactly 1 cycle.
- **Reset mid-edit:** an asynchronous reset at any point returns everything to the reset values, and no strobe is emitted.
- **Strobe exclusivity:** `clset` and `alset` are never high together, and never high outside COMMIT.

## Structure
- **Shared package** holds:
  - The FSM state enum.
  - The digit-index constants H1=0, H0=1, M1=2, M0=3.
  - The digit limits: H1_MAX=2, H0_MAX=9, H0_MAX_AT_20=3, M1_MAX=5, M0_MAX=9.
- **Sub-module `btn_debounce`**, instantiated four times:
  - Contains the synchronizer, the stability counter and the edge pulse.
  - Parameter `DB_CYCLES`; ports `clk`, `rst`, `raw`, `level`, `press`.

## Test plan
- **Clock edit:** `cur`=13:47. Press set, inc×1, next, then next×3 → `clset` high 1 cycle with bus 23:47 (H1=2, H0=3, M1=4, M0=7).
- **H0 clamp:** in a clock edit from 19:00, inc H1 once → H1=2, H0 forced to 0. Then inc H0 ×4 → H0 = 0→1→2→3→0.
- **Alarm edit:** press alm, set 06:30, commit → `alset` pulse with bus 06:30, no `clset`. A second alm press preloads 06:30.
- **Debounce:** `DB_CYCLES`=16, raw inc glitches of 10 cycles → no increment. A clean 30-cycle press → exactly one increment.
- **Timeout:** `TIMEOUT`=64, enter an edit, no presses for 64 cycles → IDLE, `edit_active`=0, no strobe.
- **Priorities:** set and alm pressed in the same cycle → clock edit. inc and next in the same cycle in ED_M1 → ED_M0 with M1 unchanged. Reset asserted in ED_M0 → all outputs 0 immediately.
